// File: rtl/pueo_hdr_pkg.sv
// pueo_hdr_pkg -- shared definitions for the PUEO event-header path.
//   HDR_BEATS   : number of 64-bit beats per header
//   beat_idx_t  : beat index within a header
//   HDR_MARKER  : constant upper half-word of beat 3 (seq is OR-ed in)
//   hdr_chk()   : header checksum, also used by the receiving accumulator
package pueo_hdr_pkg;

    localparam int HDR_BEATS = 4;

    typedef logic [1:0] beat_idx_t;

    localparam beat_idx_t   LAST_BEAT  = 2'd3;
    localparam logic [31:0] HDR_MARKER = 32'hA5A5_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } hdr_state_t;

    // XOR of the six 32-bit halves of beats 0..2.
    function automatic logic [31:0] hdr_chk(input logic [63:0] b0,
                                            input logic [63:0] b1,
                                            input logic [63:0] b2);
        return b0[63:32] ^ b0[31:0] ^ b1[63:32] ^ b1[31:0] ^ b2[63:32] ^ b2[31:0];
    endfunction

endpackage

// File: rtl/hdr_beat_gen.sv
// hdr_beat_gen -- turns one event descriptor into a 4-beat AXI4-Stream header.
//   Beat 0 : {evt_number, evt_time}
//   Beat 1 : {trig_mask, seq, 14'h0, TIO_ID}
//   Beat 2 : status
//   Beat 3 : {HDR_MARKER | seq, chk}   (m_hdr_tlast high)
// Ports:
//   aclk, aresetn             clock, asynchronous active-low reset
//   evt_valid_i / evt_ready_o descriptor handshake; evt_number_i, evt_time_i,
//                             trig_mask_i, status_i are the descriptor fields
//   m_hdr_*                   AXI4-Stream header master
//   seq_o                     number of headers fully sent (wraps at 16 bits)
// Configuration macro: HDR_TX_CHECKSUM_EN -- when defined, chk is the XOR
// checksum of beats 0..2; otherwise chk is zero and no checksum logic exists.
module hdr_beat_gen
    import pueo_hdr_pkg::*;
#(
    parameter logic [1:0] TIO_ID = 2'd0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        evt_valid_i,
    output logic        evt_ready_o,
    input  logic [31:0] evt_number_i,
    input  logic [31:0] evt_time_i,
    input  logic [31:0] trig_mask_i,
    input  logic [63:0] status_i,
    output logic [63:0] m_hdr_tdata,
    output logic        m_hdr_tvalid,
    input  logic        m_hdr_tready,
    output logic        m_hdr_tlast,
    output logic [15:0] seq_o
);

    hdr_state_t  state_r, state_nxt_s;
    beat_idx_t   beat_r, beat_nxt_s, nxt_idx_s;
    logic        ready_en_r;
    logic [63:0] tdata_r, tdata_nxt_s, nxt_word_s;
    logic        tvalid_r, tvalid_nxt_s;
    logic        tlast_r, tlast_nxt_s;
    logic [15:0] seq_r, seq_nxt_s;
    logic [31:0] mask_r;
    logic [63:0] status_r;
    logic [15:0] seq_cap_r;
    logic [31:0] chk_s;
    logic        hs_s, last_hs_s, evt_ready_s, accept_s;

    assign hs_s        = tvalid_r & m_hdr_tready;
    assign last_hs_s   = (state_r == ST_SEND) && (beat_r == LAST_BEAT) && hs_s;
    // The output register empties on the beat-3 handshake, so a new
    // descriptor can be taken in that same cycle without a bubble.
    assign evt_ready_s = ((state_r == ST_IDLE) && ready_en_r) || last_hs_s;
    assign accept_s    = evt_valid_i && evt_ready_s;
    // A descriptor taken during the beat-3 handshake carries the
    // post-increment count, i.e. the number of headers sent once this edge lands.
    assign seq_nxt_s   = last_hs_s ? (seq_r + 16'd1) : seq_r;
    assign nxt_idx_s   = beat_r + 2'd1;

`ifdef HDR_TX_CHECKSUM_EN
    logic [31:0] chk_r;
    assign chk_s = chk_r;

    // Checksum captured together with the descriptor fields.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            chk_r <= 32'h0;
        end else if (accept_s) begin
            chk_r <= hdr_chk({evt_number_i, evt_time_i},
                             {trig_mask_i, seq_nxt_s, 14'h0, TIO_ID},
                             status_i);
        end
    end
`else
    assign chk_s = 32'h0;
`endif

    // Word for the beat that follows the one currently presented.
    always_comb begin
        nxt_word_s = 64'h0;
        case (nxt_idx_s)
            2'd1:    nxt_word_s = {mask_r, seq_cap_r, 14'h0, TIO_ID};
            2'd2:    nxt_word_s = status_r;
            2'd3:    nxt_word_s = {HDR_MARKER | {16'h0, seq_cap_r}, chk_s};
            default: nxt_word_s = 64'h0;
        endcase
    end

    // Next-state and next-output logic for the beat sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        beat_nxt_s   = beat_r;
        tdata_nxt_s  = tdata_r;
        tvalid_nxt_s = tvalid_r;
        tlast_nxt_s  = tlast_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s  = ST_SEND;
                    beat_nxt_s   = 2'd0;
                    tdata_nxt_s  = {evt_number_i, evt_time_i};
                    tvalid_nxt_s = 1'b1;
                    tlast_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (hs_s && (beat_r == LAST_BEAT)) begin
                    if (accept_s) begin
                        state_nxt_s  = ST_SEND;
                        beat_nxt_s   = 2'd0;
                        tdata_nxt_s  = {evt_number_i, evt_time_i};
                        tvalid_nxt_s = 1'b1;
                        tlast_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                        beat_nxt_s   = 2'd0;
                        tdata_nxt_s  = 64'h0;
                        tvalid_nxt_s = 1'b0;
                        tlast_nxt_s  = 1'b0;
                    end
                end else if (hs_s) begin
                    beat_nxt_s  = nxt_idx_s;
                    tdata_nxt_s = nxt_word_s;
                    tlast_nxt_s = (nxt_idx_s == LAST_BEAT);
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                beat_nxt_s   = 2'd0;
                tdata_nxt_s  = 64'h0;
                tvalid_nxt_s = 1'b0;
                tlast_nxt_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered stream outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r  <= ST_IDLE;
            beat_r   <= 2'd0;
            tdata_r  <= 64'h0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            beat_r   <= beat_nxt_s;
            tdata_r  <= tdata_nxt_s;
            tvalid_r <= tvalid_nxt_s;
            tlast_r  <= tlast_nxt_s;
        end
    end

    // Descriptor fields for beats 1..3, frozen for the packet in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mask_r    <= 32'h0;
            status_r  <= 64'h0;
            seq_cap_r <= 16'h0;
        end else if (accept_s) begin
            mask_r    <= trig_mask_i;
            status_r  <= status_i;
            seq_cap_r <= seq_nxt_s;
        end
    end

    // Sent-header counter and the one-edge ready enable after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            seq_r      <= 16'h0;
            ready_en_r <= 1'b0;
        end else begin
            seq_r      <= seq_nxt_s;
            ready_en_r <= 1'b1;
        end
    end

    assign evt_ready_o  = evt_ready_s;
    assign m_hdr_tdata  = tdata_r;
    assign m_hdr_tvalid = tvalid_r;
    assign m_hdr_tlast  = tlast_r;
    assign seq_o        = seq_r;

endmodule
